// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the two-requester RAM arbiter: default address
//   and data widths, the arbiter FSM state encoding and the requester IDs
//   used for the winner and last_grant registers.
package ram_arbiter_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage : ram_arbiter_pkg

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-input round-robin grant. A lone valid requester wins outright; when
//   both are valid, the one that was not granted most recently wins.
// Ports:
//   a_valid_i, b_valid_i  request bits from requester A and B
//   last_grant_i          ID of the requester granted most recently
//   a_grant_o, b_grant_o  one-hot (or all-zero) grant
//   winner_o              ID of the granted requester (REQ_A when none)
module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic last_grant_i,
  output logic a_grant_o,
  output logic b_grant_o,
  output logic winner_o
);

  // Grant selection with round-robin tie break
  always_comb begin
    a_grant_o = 1'b0;
    b_grant_o = 1'b0;
    if (a_valid_i && b_valid_i) begin
      if (last_grant_i == REQ_B) begin
        a_grant_o = 1'b1;
      end else begin
        b_grant_o = 1'b1;
      end
    end else if (a_valid_i) begin
      a_grant_o = 1'b1;
    end else if (b_valid_i) begin
      b_grant_o = 1'b1;
    end else begin
      a_grant_o = 1'b0;
      b_grant_o = 1'b0;
    end
    winner_o = b_grant_o ? REQ_B : REQ_A;
  end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port synchronous RAM between two requesters. Each
//   transaction runs IDLE -> ISSUE -> RESP: the request is accepted in IDLE,
//   driven to the RAM during ISSUE, and completed with a one-cycle response
//   pulse in RESP (read data arrives from the RAM in that cycle).
// Ports:
//   gated_clk, reset_n          clock, synchronous active-low reset
//   a_req_* / b_req_*           valid/ready request handshake with wr/addr/wdata
//   a_rsp_* / b_rsp_*           completion pulse and read data
//   ram_en, ram_r, ram_address,
//   ram_data, ram_out           RAM port (ram_r = 1 selects read)
//   busy                        high whenever a transaction is in flight
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
  input  logic              gated_clk,
  input  logic              reset_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_wr,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_wr,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              ram_en,
  output logic              ram_r,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  state_e            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              wr_q;
  logic              busy_q;
  logic              ram_en_q;
  logic              ram_r_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              a_rsp_valid_q;
  logic              b_rsp_valid_q;

  logic              a_grant_s;
  logic              b_grant_s;
  logic              winner_s;
  logic              idle_s;
  logic              accept_s;
  logic              sel_wr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_arb2 u_rr_arb2 (
    .a_valid_i    (a_req_valid),
    .b_valid_i    (b_req_valid),
    .last_grant_i (last_grant_q),
    .a_grant_o    (a_grant_s),
    .b_grant_o    (b_grant_s),
    .winner_o     (winner_s)
  );

  // Handshake: ready only in IDLE and never while reset is held
  always_comb begin
    idle_s      = (state_q == IDLE) && reset_n;
    a_req_ready = idle_s && a_grant_s;
    b_req_ready = idle_s && b_grant_s;
    accept_s    = a_req_ready || b_req_ready;
  end

  // Winner's request fields, captured on acceptance
  always_comb begin
    if (winner_s == REQ_B) begin
      sel_wr_s    = b_req_wr;
      sel_addr_s  = b_req_addr;
      sel_wdata_s = b_req_wdata;
    end else begin
      sel_wr_s    = a_req_wr;
      sel_addr_s  = a_req_addr;
      sel_wdata_s = a_req_wdata;
    end
  end

  // Arbiter FSM with registered RAM-side and response-valid outputs
  always_ff @(posedge gated_clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_B;
      owner_q       <= REQ_A;
      wr_q          <= 1'b0;
      busy_q        <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_r_q       <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q       <= ISSUE;
            last_grant_q  <= winner_s;
            owner_q       <= winner_s;
            wr_q          <= sel_wr_s;
            busy_q        <= 1'b1;
            ram_en_q      <= 1'b1;
            ram_r_q       <= ~sel_wr_s;
            ram_address_q <= sel_addr_s;
            ram_data_q    <= sel_wdata_s;
          end
        end
        ISSUE: begin
          state_q       <= RESP;
          ram_en_q      <= 1'b0;
          ram_r_q       <= 1'b0;
          ram_address_q <= '0;
          ram_data_q    <= '0;
          a_rsp_valid_q <= (owner_q == REQ_A);
          b_rsp_valid_q <= (owner_q == REQ_B);
        end
        RESP: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          a_rsp_valid_q <= 1'b0;
          b_rsp_valid_q <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          ram_en_q      <= 1'b0;
          ram_r_q       <= 1'b0;
          ram_address_q <= '0;
          ram_data_q    <= '0;
          a_rsp_valid_q <= 1'b0;
          b_rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Read data flows straight from the RAM in RESP; zero otherwise
  always_comb begin
    if (a_rsp_valid_q && !wr_q) begin
      a_rsp_rdata = ram_out;
    end else begin
      a_rsp_rdata = '0;
    end
    if (b_rsp_valid_q && !wr_q) begin
      b_rsp_rdata = ram_out;
    end else begin
      b_rsp_rdata = '0;
    end
  end

  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign ram_en      = ram_en_q;
  assign ram_r       = ram_r_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign busy        = busy_q;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed testbench for ram_arbiter with a behavioural synchronous RAM.
//   Inputs change 1 time unit after the rising edge; outputs are checked on
//   the falling edge.
module tb_ram_arbiter;

  logic       gated_clk;
  logic       reset_n;
  logic       a_req_valid, a_req_ready, a_req_wr;
  logic [5:0] a_req_addr;
  logic [7:0] a_req_wdata;
  logic       a_rsp_valid;
  logic [7:0] a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_req_wr;
  logic [5:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;
  logic       ram_en, ram_r;
  logic [5:0] ram_address;
  logic [7:0] ram_data;
  logic [7:0] ram_out;
  logic       busy;

  logic [7:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter dut (
    .gated_clk   (gated_clk),
    .reset_n     (reset_n),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_wr    (a_req_wr),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_wr    (b_req_wr),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata),
    .ram_en      (ram_en),
    .ram_r       (ram_r),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_out     (ram_out),
    .busy        (busy)
  );

  initial gated_clk = 1'b0;
  always #5 gated_clk = ~gated_clk;

  // Behavioural synchronous RAM: read data appears after the read edge
  always @(posedge gated_clk) begin
    if (ram_en) begin
      if (ram_r) ram_out <= mem[ram_address];
      else       mem[ram_address] <= ram_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge gated_clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ram_en"},  {31'd0, ram_en}, 32'd0);
    chk({tag, ".ram_r"},   {31'd0, ram_r}, 32'd0);
    chk({tag, ".ram_addr"}, {26'd0, ram_address}, 32'd0);
    chk({tag, ".ram_data"}, {24'd0, ram_data}, 32'd0);
    chk({tag, ".a_rsp_v"}, {31'd0, a_rsp_valid}, 32'd0);
    chk({tag, ".b_rsp_v"}, {31'd0, b_rsp_valid}, 32'd0);
    chk({tag, ".a_rdata"}, {24'd0, a_rsp_rdata}, 32'd0);
    chk({tag, ".b_rdata"}, {24'd0, b_rsp_rdata}, 32'd0);
    chk({tag, ".busy"},    {31'd0, busy}, 32'd0);
  endtask

  // One isolated transaction from a single requester, checked cycle by cycle
  task automatic do_txn(input string tag, input logic use_a, input logic wr,
                        input logic [5:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rd);
    if (use_a) begin
      a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_wdata = wd;
    end else begin
      b_req_valid = 1'b1; b_req_wr = wr; b_req_addr = addr; b_req_wdata = wd;
    end
    @(negedge gated_clk);
    chk({tag, ".a_ready"}, {31'd0, a_req_ready}, {31'd0, use_a});
    chk({tag, ".b_ready"}, {31'd0, b_req_ready}, {31'd0, ~use_a});
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    next_cycle();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(negedge gated_clk);
    chk({tag, ".iss_en"},   {31'd0, ram_en}, 32'd1);
    chk({tag, ".iss_r"},    {31'd0, ram_r}, {31'd0, ~wr});
    chk({tag, ".iss_addr"}, {26'd0, ram_address}, {26'd0, addr});
    chk({tag, ".iss_data"}, {24'd0, ram_data}, {24'd0, wd});
    chk({tag, ".iss_busy"}, {31'd0, busy}, 32'd1);
    next_cycle();
    @(negedge gated_clk);
    chk({tag, ".rsp_a_v"}, {31'd0, a_rsp_valid}, {31'd0, use_a});
    chk({tag, ".rsp_b_v"}, {31'd0, b_rsp_valid}, {31'd0, ~use_a});
    chk({tag, ".rsp_rd"},  {24'd0, (use_a ? a_rsp_rdata : b_rsp_rdata)}, {24'd0, exp_rd});
    chk({tag, ".rsp_other_rd"}, {24'd0, (use_a ? b_rsp_rdata : a_rsp_rdata)}, 32'd0);
    chk({tag, ".rsp_en"},  {31'd0, ram_en}, 32'd0);
    next_cycle();
  endtask

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_a;
    for (int i = 0; i < 64; i++) mem[i] = 8'hA5;
    ram_out = 8'h00;
    reset_n = 1'b0;
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 6'd0; a_req_wdata = 8'd0;
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 6'd0; b_req_wdata = 8'd0;

    // Reset with both requesters valid: no ready, quiet outputs
    next_cycle();
    next_cycle();
    @(negedge gated_clk);
    chk("rst.a_ready", {31'd0, a_req_ready}, 32'd0);
    chk("rst.b_ready", {31'd0, b_req_ready}, 32'd0);
    chk_quiet("rst");
    next_cycle();
    reset_n = 1'b1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;

    // A writes 0x2A to 0x05, B reads it back
    do_txn("a_wr05", 1'b1, 1'b1, 6'h05, 8'h2A, 8'h00);
    do_txn("b_rd05", 1'b0, 1'b0, 6'h05, 8'h00, 8'h2A);

    // Both held valid: A,B,A,B alternation (last grant is B)
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 6'h05; a_req_wdata = 8'h00;
    b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = 6'h07; b_req_wdata = 8'h77;
    exp_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge gated_clk);
      chk("rr.a_ready", {31'd0, a_req_ready}, {31'd0, exp_a});
      chk("rr.b_ready", {31'd0, b_req_ready}, {31'd0, ~exp_a});
      next_cycle();
      @(negedge gated_clk);
      chk("rr.iss_noready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
      chk("rr.iss_addr", {26'd0, ram_address}, exp_a ? 32'h05 : 32'h07);
      next_cycle();
      @(negedge gated_clk);
      chk("rr.rsp_noready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
      chk("rr.a_rsp_v", {31'd0, a_rsp_valid}, {31'd0, exp_a});
      chk("rr.b_rsp_v", {31'd0, b_rsp_valid}, {31'd0, ~exp_a});
      chk("rr.a_rdata", {24'd0, a_rsp_rdata}, exp_a ? 32'h2A : 32'h00);
      chk("rr.b_rdata", {24'd0, b_rsp_rdata}, 32'h00);
      next_cycle();
      exp_a = ~exp_a;
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    chk("rr.b_wrote", {24'd0, mem[7]}, 32'h77);

    // B raises valid during A's ISSUE; it waits for IDLE
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 6'h08; a_req_wdata = 8'h33;
    @(negedge gated_clk);
    chk("late.a_ready", {31'd0, a_req_ready}, 32'd1);
    next_cycle();
    a_req_valid = 1'b0;
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 6'h08; b_req_wdata = 8'h00;
    @(negedge gated_clk);
    chk("late.iss_b_ready", {31'd0, b_req_ready}, 32'd0);
    chk("late.iss_data", {24'd0, ram_data}, 32'h33);
    next_cycle();
    @(negedge gated_clk);
    chk("late.rsp_b_ready", {31'd0, b_req_ready}, 32'd0);
    chk("late.a_rsp_v", {31'd0, a_rsp_valid}, 32'd1);
    next_cycle();
    @(negedge gated_clk);
    chk("late.b_ready", {31'd0, b_req_ready}, 32'd1);
    next_cycle();
    b_req_valid = 1'b0;
    @(negedge gated_clk);
    chk("late.iss_r", {31'd0, ram_r}, 32'd1);
    chk("late.iss_addr", {26'd0, ram_address}, 32'h08);
    next_cycle();
    @(negedge gated_clk);
    chk("late.b_rsp_v", {31'd0, b_rsp_valid}, 32'd1);
    chk("late.b_rdata", {24'd0, b_rsp_rdata}, 32'h33);
    next_cycle();

    // Reset during ISSUE of an A read aborts it
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 6'h05; a_req_wdata = 8'h00;
    @(negedge gated_clk);
    chk("abort.a_ready", {31'd0, a_req_ready}, 32'd1);
    next_cycle();
    a_req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge gated_clk);
    chk("abort.iss_en", {31'd0, ram_en}, 32'd1);
    next_cycle();
    b_req_valid = 1'b1;
    @(negedge gated_clk);
    chk_quiet("abort");
    chk("abort.b_ready_in_rst", {31'd0, b_req_ready}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    b_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge gated_clk);
      chk("abort.no_rsp", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
      chk("abort.busy", {31'd0, busy}, 32'd0);
      next_cycle();
    end

    // Address boundaries
    do_txn("wr3f", 1'b1, 1'b1, 6'h3F, 8'hFF, 8'h00);
    do_txn("wr00", 1'b0, 1'b1, 6'h00, 8'h00, 8'h00);
    do_txn("rd3f", 1'b0, 1'b0, 6'h3F, 8'h00, 8'hFF);
    do_txn("rd00", 1'b1, 1'b0, 6'h00, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_arbiter
